// File: rtl/conv_result_writer_pkg.sv
// Shared types and pixel conversion for the conv result writer.
// Package name matches the conv-side naming used by the producer block.
package conv_io_pkg;

    localparam int DATA_W        = 32;
    localparam int PIX_W         = 8;
    localparam int PAD_VALUE_DEF = 0;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_t;

    // One extra magnitude bit so the most-negative input maps to 2^(DATA_W-1).
    function automatic pix_t abs_sat(input logic signed [DATA_W-1:0] value,
                                     input logic                     saturate);
        logic [DATA_W:0] mag;
        pix_t            pix;
        if (value[DATA_W-1]) begin
            mag = {1'b0, ~value} + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            mag = {1'b0, value};
        end
        if (saturate && (|mag[DATA_W:PIX_W])) begin
            pix = {PIX_W{1'b1}};
        end else begin
            pix = mag[PIX_W-1:0];
        end
        return pix;
    endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Result stream from conv plus the frame-buffer write port.
// slave is the writer's view, master is the environment's view.
interface conv_result_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] result;
    logic                         resultValid;
    logic                         out_accepting_values;
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [PIX_WIDTH-1:0]         wr_data;
    logic                         wr_ready;

    modport master (
        output result, resultValid, wr_ready,
        input  out_accepting_values, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  result, resultValid, wr_ready,
        output out_accepting_values, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_result_writer_fifo.sv
// Ingress pixel FIFO with a registered output stage; count covers the
// storage array and the output stage together, so capacity is DEPTH.
module result_fifo
    import conv_io_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  pix_t          push_data,
    input  logic          pop,
    output pix_t          pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    pix_t          mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] mem_cnt_r;
    logic          out_valid_r;
    pix_t          out_data_r;

    logic push_ok_s;
    logic pop_ok_s;
    logic load_out_s;

    assign count      = mem_cnt_r + CW'(out_valid_r);
    assign full       = (count == CW'(DEPTH));
    assign empty      = !out_valid_r;
    assign pop_data   = out_data_r;
    assign push_ok_s  = push && !full;
    assign pop_ok_s   = pop && out_valid_r;
    assign load_out_s = (mem_cnt_r != {CW{1'b0}}) && (!out_valid_r || pop_ok_s);

    // Storage array write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the output stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            mem_cnt_r   <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {PIX_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (load_out_s) begin
                rd_ptr_r    <= rd_ptr_r + PW'(1);
                out_data_r  <= mem_r[rd_ptr_r];
                out_valid_r <= 1'b1;
            end else if (pop_ok_s) begin
                out_valid_r <= 1'b0;
            end
            case ({push_ok_s, load_out_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CW'(1);
                2'b01:   mem_cnt_r <= mem_cnt_r - CW'(1);
                default: mem_cnt_r <= mem_cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Accepts conv results, converts them to magnitude pixels and writes them in
// raster order into a frame buffer, surrounded by a constant padding ring.
module conv_result_writer
    import conv_io_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int PIX_WIDTH  = PIX_W,
    parameter int MAX_DIM    = 224,
    parameter int PAD        = 1,
    parameter int PAD_VALUE  = PAD_VALUE_DEF,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SATURATE   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           out_dim,
    conv_result_writer_if.slave  bus,
    output logic                 busy,
    output logic                 done
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    typedef logic [ADDR_WIDTH-1:0] cnt_t;

    wr_state_t state_r;
    cnt_t      dim_r;
    cnt_t      side_r;
    cnt_t      dd_r;
    cnt_t      last_addr_r;
    cnt_t      acc_cnt_r;
    cnt_t      x_r;
    cnt_t      y_r;
    cnt_t      ptr_r;
    logic      all_loaded_r;
    logic      wr_en_r;
    cnt_t      wr_addr_r;
    pix_t      wr_data_r;
    logic      busy_r;
    logic      done_r;

    cnt_t                   dim_in_s;
    cnt_t                   side_in_s;
    cnt_t                   dd_in_s;
    cnt_t                   last_in_s;
    logic signed [DATA_WIDTH-1:0] result_s;
    logic [PIX_WIDTH-1:0]   pad_pix_s;
    logic                   ready_s;
    logic                   push_s;
    pix_t                   push_pix_s;
    logic                   is_pad_s;
    logic                   slot_free_s;
    logic                   load_s;
    logic                   pop_s;
    logic                   accept_s;
    logic                   last_accept_s;
    pix_t                   fifo_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [FCW-1:0]         fifo_count_s;

    assign dim_in_s  = (cnt_t'(out_dim) > cnt_t'(MAX_DIM)) ? cnt_t'(MAX_DIM) : cnt_t'(out_dim);
    assign side_in_s = dim_in_s + cnt_t'(2 * PAD);
    assign dd_in_s   = cnt_t'(dim_in_s * dim_in_s);
    assign last_in_s = cnt_t'(side_in_s * side_in_s) - cnt_t'(1);

    assign result_s   = bus.result;
    assign pad_pix_s  = PIX_WIDTH'(PAD_VALUE);
    assign push_pix_s = abs_sat(result_s, SATURATE != 0);

    // Ready depends only on registered state, never on a same-cycle pop.
    assign ready_s = (state_r == RUN) && !fifo_full_s && (acc_cnt_r < dd_r);
    assign push_s  = bus.resultValid && ready_s;

    assign is_pad_s = (x_r < cnt_t'(PAD)) || (x_r >= cnt_t'(PAD) + dim_r) ||
                      (y_r < cnt_t'(PAD)) || (y_r >= cnt_t'(PAD) + dim_r);

    // The output register can take a new write when empty or being drained.
    assign slot_free_s   = !wr_en_r || bus.wr_ready;
    assign load_s        = (state_r == RUN) && !all_loaded_r && slot_free_s &&
                           (is_pad_s || !fifo_empty_s);
    assign pop_s         = load_s && !is_pad_s;
    assign accept_s      = wr_en_r && bus.wr_ready;
    assign last_accept_s = accept_s && (wr_addr_r == last_addr_r);

    result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_pix_s),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Frame sequencing, raster position and registered write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            dim_r        <= {ADDR_WIDTH{1'b0}};
            side_r       <= {ADDR_WIDTH{1'b0}};
            dd_r         <= {ADDR_WIDTH{1'b0}};
            last_addr_r  <= {ADDR_WIDTH{1'b0}};
            acc_cnt_r    <= {ADDR_WIDTH{1'b0}};
            x_r          <= {ADDR_WIDTH{1'b0}};
            y_r          <= {ADDR_WIDTH{1'b0}};
            ptr_r        <= {ADDR_WIDTH{1'b0}};
            all_loaded_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_data_r    <= {PIX_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r  <= 1'b0;
                    wr_en_r <= 1'b0;
                    if (start) begin
                        state_r      <= RUN;
                        busy_r       <= 1'b1;
                        dim_r        <= dim_in_s;
                        side_r       <= side_in_s;
                        dd_r         <= dd_in_s;
                        last_addr_r  <= last_in_s;
                        acc_cnt_r    <= {ADDR_WIDTH{1'b0}};
                        x_r          <= {ADDR_WIDTH{1'b0}};
                        y_r          <= {ADDR_WIDTH{1'b0}};
                        ptr_r        <= {ADDR_WIDTH{1'b0}};
                        all_loaded_r <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (push_s) begin
                        acc_cnt_r <= acc_cnt_r + cnt_t'(1);
                    end
                    if (load_s) begin
                        wr_en_r      <= 1'b1;
                        wr_addr_r    <= ptr_r;
                        wr_data_r    <= is_pad_s ? pad_pix_s : fifo_data_s;
                        ptr_r        <= ptr_r + cnt_t'(1);
                        all_loaded_r <= (ptr_r == last_addr_r);
                        if (x_r == side_r - cnt_t'(1)) begin
                            x_r <= {ADDR_WIDTH{1'b0}};
                            y_r <= y_r + cnt_t'(1);
                        end else begin
                            x_r <= x_r + cnt_t'(1);
                        end
                    end else if (accept_s) begin
                        wr_en_r <= 1'b0;
                    end
                    if (last_accept_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_accepting_values = ready_s;
    assign bus.wr_en                = wr_en_r;
    assign bus.wr_addr              = wr_addr_r;
    assign bus.wr_data              = wr_data_r;
    assign busy                     = busy_r;
    assign done                     = done_r;

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench: a raster model predicts every frame-buffer write for a
// saturating and a truncating writer driven by the same random stimulus.
module tb_conv_result_writer;

    typedef struct {
        int addr;
        int sat;
        int trunc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] out_dim;
    logic       busy_s, done_s, busy_t, done_t;

    conv_result_writer_if bus_s ();
    conv_result_writer_if bus_t ();

    assign bus_t.result      = bus_s.result;
    assign bus_t.resultValid = bus_s.resultValid;
    assign bus_t.wr_ready    = bus_s.wr_ready;

    conv_result_writer #(.SATURATE(1)) dut_sat (
        .clock (clock), .reset (reset), .start (start), .out_dim (out_dim),
        .bus (bus_s), .busy (busy_s), .done (done_s)
    );

    conv_result_writer #(.SATURATE(0)) dut_trunc (
        .clock (clock), .reset (reset), .start (start), .out_dim (out_dim),
        .bus (bus_t), .busy (busy_t), .done (done_t)
    );

    always #5 clock = ~clock;

    int   tests = 0;
    int   fails = 0;
    int   stim_q[$];
    exp_t exp_q[$];
    int   prod_acc = 0;
    int   wr_total = 0;
    int   done_cnt = 0;
    int   last_acc = -1;
    int   exp_last = 0;
    bit   gaps = 1'b0;
    bit   rdy_rand = 1'b0;
    bit   hold_ready = 1'b0;
    int   cur_d, cur_f, done_base, acc_base, nres_base, wr_base;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_pix(input int r, output int s, output int t);
        longint m;
        m = (r < 0) ? -longint'(r) : longint'(r);
        s = (m > 255) ? 255 : int'(m);
        t = int'(m % 256);
    endfunction

    function automatic int img(input int y, input int x);
        return ((y * 37 + x * 91 + (y * x) % 53) ^ (y * 4)) & 255;
    endfunction

    function automatic int sobel(input int cy, input int cx);
        int gx, gy;
        gx = img(cy-1, cx+1) + 2*img(cy, cx+1) + img(cy+1, cx+1)
           - img(cy-1, cx-1) - 2*img(cy, cx-1) - img(cy+1, cx-1);
        gy = img(cy+1, cx-1) + 2*img(cy+1, cx) + img(cy+1, cx+1)
           - img(cy-1, cx-1) - 2*img(cy-1, cx) - img(cy-1, cx+1);
        return gx + gy;
    endfunction

    function automatic int rand_res();
        case ($urandom_range(0, 5))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'(32'h8000_0000);
            2:       return int'(32'h7fff_ffff);
            3:       return int'($urandom_range(0, 255));
            default: return int'($urandom);
        endcase
    endfunction

    // Raster-order reference: ring of zeros around the D x D result block.
    task automatic build_expect(input int d);
        int   f, k;
        exp_t e;
        f = d + 2;
        k = 0;
        for (int y = 0; y < f; y++) begin
            for (int x = 0; x < f; x++) begin
                e.addr = y * f + x;
                if (x < 1 || x >= 1 + d || y < 1 || y >= 1 + d) begin
                    e.sat = 0;
                    e.trunc = 0;
                end else begin
                    ref_pix(stim_q[k], e.sat, e.trunc);
                    k++;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input int dim_in);
        cur_d     = (dim_in > 224) ? 224 : dim_in;
        cur_f     = cur_d + 2;
        exp_last  = cur_f * cur_f - 1;
        build_expect(cur_d);
        done_base = done_cnt;
        acc_base  = prod_acc;
        nres_base = stim_q.size();
        wr_base   = wr_total;
        out_dim   = 8'(dim_in);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy_s, 1);
    endtask

    task automatic finish_frame();
        int budget;
        int exp_acc;
        budget = (cur_f * cur_f * 3) / 2 + 200;
        while (done_cnt == done_base && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: no done within budget, d=%0d", cur_d);
        end
        repeat (3) @(negedge clock);
        exp_acc = (nres_base < cur_d * cur_d) ? nres_base : cur_d * cur_d;
        check("done_pulses", done_cnt - done_base, 1);
        check("write_count", wr_total - wr_base, cur_f * cur_f);
        check("accepted", prod_acc - acc_base, exp_acc);
        check("exp_drained", exp_q.size(), 0);
    endtask

    // Producer: holds data while not accepted, optional random idle cycles.
    initial begin
        bit fired;
        fired = 1'b0;
        bus_s.resultValid = 1'b0;
        bus_s.result = '0;
        forever begin
            @(negedge clock);
            if (!bus_s.resultValid || fired) begin
                if (stim_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    bus_s.resultValid = 1'b1;
                    bus_s.result = stim_q[0];
                end else begin
                    bus_s.resultValid = 1'b0;
                end
            end
            if (stim_q.size() == 0) bus_s.resultValid = 1'b0;
            fired = 1'b0;
            #1;
            if (bus_s.resultValid && bus_s.out_accepting_values) begin
                void'(stim_q.pop_front());
                prod_acc++;
                fired = 1'b1;
            end
        end
    end

    // Frame-buffer side readiness.
    initial begin
        bus_s.wr_ready = 1'b0;
        forever begin
            @(negedge clock);
            bus_s.wr_ready = hold_ready ? 1'b0 :
                             (rdy_rand ? ($urandom_range(0, 7) != 0) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard on every accepted write, checks stall hold and done.
    initial begin
        bit   stall_prev;
        int   prev_addr, prev_data;
        exp_t e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_wr_en", bus_s.wr_en, 1);
                    check("hold_wr_addr", bus_s.wr_addr, prev_addr);
                    check("hold_wr_data", bus_s.wr_data, prev_data);
                end
                if (bus_s.wr_en && bus_s.wr_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_write: addr %0d with no write expected", bus_s.wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus_s.wr_addr, e.addr);
                        check("wr_data_sat", bus_s.wr_data, e.sat);
                        check("wr_addr_trunc", bus_t.wr_addr, e.addr);
                        check("wr_data_trunc", bus_t.wr_data, e.trunc);
                    end
                    wr_total++;
                    last_acc = bus_s.wr_addr;
                end
                stall_prev = bus_s.wr_en && !bus_s.wr_ready;
                prev_addr  = bus_s.wr_addr;
                prev_data  = bus_s.wr_data;
                if (done_s) begin
                    done_cnt++;
                    check("done_after_last", last_acc, exp_last);
                    check("done_exp_left", exp_q.size(), 0);
                    check("done_busy_low", busy_s, 0);
                    check("done_trunc", done_t, 1);
                end
            end
        end
    end

    initial begin
        int budget, low, d;
        reset = 1'b1;
        start = 1'b0;
        out_dim = 8'd0;
        repeat (3) @(negedge clock);
        check("rst_ready", bus_s.out_accepting_values, 0);
        check("rst_wr_en", bus_s.wr_en, 0);
        check("rst_wr_addr", bus_s.wr_addr, 0);
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        reset = 1'b0;
        @(negedge clock);

        // Magnitude and saturation, plus truncation on the second writer.
        stim_q = '{10, -20, 300, -300};
        start_frame(2);
        finish_frame();

        // Five results offered to a 2x2 frame: the fifth must stay pending.
        stim_q = '{5, -6, 7, -8, 9};
        start_frame(2);
        finish_frame();
        check("excess_left", stim_q.size(), 1);
        stim_q.delete();
        repeat (2) @(negedge clock);

        // Backpressure: stall the frame buffer mid-row while results keep coming.
        for (int i = 0; i < 16; i++) stim_q.push_back(rand_res());
        start_frame(4);
        budget = 200;
        while (wr_total - wr_base < 8 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        hold_ready = 1'b1;
        low = 0;
        repeat (9) begin
            @(negedge clock);
            #3;
            if (!bus_s.out_accepting_values && (prod_acc - acc_base) < 16) low++;
        end
        hold_ready = 1'b0;
        check("bp_ready_dropped", low > 0, 1);
        finish_frame();

        // Reset mid-frame after seven writes, then a clean restart.
        for (int i = 0; i < 9; i++) stim_q.push_back(rand_res());
        start_frame(3);
        budget = 200;
        while (wr_total - wr_base < 7 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", bus_s.out_accepting_values, 0);
        check("midrst_wr_en", bus_s.wr_en, 0);
        check("midrst_wr_addr", bus_s.wr_addr, 0);
        check("midrst_wr_data", bus_s.wr_data, 0);
        check("midrst_busy", busy_s, 0);
        check("midrst_done", done_s, 0);
        stim_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 9; i++) stim_q.push_back(rand_res());
        start_frame(3);
        finish_frame();

        // Empty valid region: padding only.
        start_frame(0);
        finish_frame();

        // Random small frames with gaps, random ready and ignored mid-frame starts.
        gaps = 1'b1;
        rdy_rand = 1'b1;
        repeat (4) begin
            d = $urandom_range(1, 6);
            for (int i = 0; i < d * d; i++) stim_q.push_back(rand_res());
            start_frame(d);
            repeat (2) @(negedge clock);
            out_dim = 8'($urandom_range(0, 255));
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            finish_frame();
        end

        // Full 224x224 frame of Sobel responses with random write readiness.
        gaps = 1'b0;
        for (int y = 0; y < 224; y++) begin
            for (int x = 0; x < 224; x++) begin
                if (y == 4 && x == 100)      stim_q.push_back(int'(32'h8000_0000));
                else if (y == 9 && x == 200) stim_q.push_back(int'(32'h7fff_ffff));
                else                         stim_q.push_back(sobel(y + 1, x + 1));
            end
        end
        start_frame(224);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
